// File: rtl/alu_exec_unit.sv
// Handshaked execute-stage ALU: single-cycle arithmetic/logic ops plus an iterative shifter.
// Define ALU_OVF_EN to add registered carry_out/overflow outputs for ADD/SUB.
module alu_exec_unit #(
   parameter int WIDTH      = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       alu_op,
   input  logic             zero_inv,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
`ifdef ALU_OVF_EN
   output logic             carry_out,
   output logic             overflow,
`endif
   output logic             busy
);

   localparam int SW = $clog2(WIDTH);
   localparam logic [SW:0] STEP = SHIFT_STEP[SW:0];

   localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                          OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLTU = 4'd6, OP_SLL = 4'd7,
                          OP_SRL = 4'd8, OP_SRA = 4'd9;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
   state_t state_reg, state_next;

   logic [WIDTH-1:0] work_reg, calc, shifted;
   logic [SW-1:0]    rem_reg;
   logic [SW-1:0]    shamt;
   logic [SW:0]      step;
   logic [3:0]       kind_reg;
   logic             zinv_reg, is_shift, start_shift, last, accept;

   assign shamt       = op_b[SW-1:0];
   assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
   assign start_shift = is_shift && (shamt != '0);
   assign accept      = in_valid && in_ready;
   assign out_valid   = (state_reg == HOLD);
   assign busy        = (state_reg == SHIFT);

   always_comb begin
      calc = '0;
      case (alu_op)
         OP_ADD:  calc = op_a + op_b;
         OP_SUB:  calc = op_a - op_b;
         OP_AND:  calc = op_a & op_b;
         OP_OR:   calc = op_a | op_b;
         OP_XOR:  calc = op_a ^ op_b;
         OP_SLT:  calc = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OP_SLTU: calc = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
         OP_SLL, OP_SRL, OP_SRA: calc = op_a;   // only reached directly when shamt == 0
         default: calc = '0;
      endcase
   end

`ifdef ALU_OVF_EN
   logic [WIDTH:0] sum_ext, diff_ext;
   logic           calc_c, calc_v;
   assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
   assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
   always_comb begin
      calc_c = 1'b0;
      calc_v = 1'b0;
      if (alu_op == OP_ADD) begin
         calc_c = sum_ext[WIDTH];
         calc_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);
      end else if (alu_op == OP_SUB) begin
         calc_c = ~diff_ext[WIDTH];   // carry means no borrow
         calc_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff_ext[WIDTH-1] != op_a[WIDTH-1]);
      end
   end
`endif

   // Final step may be shorter than SHIFT_STEP so the total shift is exact.
   always_comb begin
      step = ({1'b0, rem_reg} > STEP) ? STEP : {1'b0, rem_reg};
      case (kind_reg)
         OP_SRL:  shifted = work_reg >> step;
         OP_SRA:  shifted = $unsigned($signed(work_reg) >>> step);
         default: shifted = work_reg << step;
      endcase
   end
   assign last = ({1'b0, rem_reg} == step);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = start_shift ? SHIFT : HOLD;
         end
         SHIFT: begin
            if (last) state_next = HOLD;
         end
         HOLD: begin
            in_ready = out_ready;
            if (out_ready) state_next = in_valid ? (start_shift ? SHIFT : HOLD) : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result    <= '0;
         zero_flag <= 1'b0;
         work_reg  <= '0;
         rem_reg   <= '0;
         kind_reg  <= '0;
         zinv_reg  <= 1'b0;
`ifdef ALU_OVF_EN
         carry_out <= 1'b0;
         overflow  <= 1'b0;
`endif
      end else if (accept) begin
         kind_reg <= alu_op;
         zinv_reg <= zero_inv;
         if (start_shift) begin
            work_reg <= op_a;
            rem_reg  <= shamt;
         end else begin
            result    <= calc;
            zero_flag <= (calc == '0) ^ zero_inv;
`ifdef ALU_OVF_EN
            carry_out <= calc_c;
            overflow  <= calc_v;
`endif
         end
      end else if (state_reg == SHIFT) begin
         work_reg <= shifted;
         rem_reg  <= rem_reg - step[SW-1:0];
         if (last) begin
            result    <= shifted;
            zero_flag <= (shifted == '0) ^ zinv_reg;
`ifdef ALU_OVF_EN
            carry_out <= 1'b0;
            overflow  <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32, SHIFT_STEP=1); ALU_OVF_EN adds flag checks.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, zero_inv, out_valid, out_ready, zero_flag, busy;
   logic [31:0] op_a, op_b, result;
   logic [3:0]  alu_op;
`ifdef ALU_OVF_EN
   logic        carry_out, overflow;
`endif
   int          tests = 0;
   int          failed = 0;
   int          cycles, busy_cnt;

   always #5 clk = ~clk;

   alu_exec_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .alu_op(alu_op), .zero_inv(zero_inv),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .zero_flag(zero_flag),
`ifdef ALU_OVF_EN
      .carry_out(carry_out), .overflow(overflow),
`endif
      .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
         $display("[TB] %-14s observed %h expected %h ok", tag, obs, exp);
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic zi);
      alu_op = op; op_a = a; op_b = b; zero_inv = zi; in_valid = 1'b1;
   endtask

   // Issue one op, return after the accepting edge.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic zi);
      drive(op, a, b, zi);
      tick();
      in_valid = 1'b0;
   endtask

   // Cycles counted from the accepting edge until out_valid, bounded.
   task automatic wait_valid(output int n, output int nbusy);
      n = 1; nbusy = 0;
      while (!out_valid && n < 200) begin
         if (busy) nbusy++;
         tick();
         n++;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op_a = '0; op_b = '0; alu_op = '0; zero_inv = 1'b0;
      tick(); tick();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero_flag", {31'b0, zero_flag}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      #2 rst = 1'b0;

      // Reset in the middle of a long shift
      tick();
      issue(4'd7, 32'd1, 32'd20, 1'b0);
      tick(); tick(); tick();
      check("mid_busy", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_result", result, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
      #2 rst = 1'b0;
      issue(4'd0, 32'd2, 32'd3, 1'b0);
      check("post_rst_valid", {31'b0, out_valid}, 32'd1);
      check("post_rst_add", result, 32'd5);

      // Wrap-around add
      issue(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("add_wrap", result, 32'd0);
      check("add_wrap_zf", {31'b0, zero_flag}, 32'd1);
`ifdef ALU_OVF_EN
      check("add_wrap_c", {31'b0, carry_out}, 32'd1);
      check("add_wrap_v", {31'b0, overflow}, 32'd0);
`endif
      issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0);
      check("add_ovf", result, 32'h8000_0000);
`ifdef ALU_OVF_EN
      check("add_ovf_c", {31'b0, carry_out}, 32'd0);
      check("add_ovf_v", {31'b0, overflow}, 32'd1);
`endif

      // Subtract with inverted zero flag (BNE)
      issue(4'd1, 32'd5, 32'd5, 1'b1);
      check("sub_eq", result, 32'd0);
      check("sub_eq_zf", {31'b0, zero_flag}, 32'd0);
      issue(4'd1, 32'd5, 32'd3, 1'b1);
      check("sub_ne", result, 32'd2);
      check("sub_ne_zf", {31'b0, zero_flag}, 32'd1);
`ifdef ALU_OVF_EN
      check("sub_ne_c", {31'b0, carry_out}, 32'd1);
      issue(4'd1, 32'd3, 32'd5, 1'b0);
      check("sub_borrow_c", {31'b0, carry_out}, 32'd0);
`endif

      // Logic ops
      issue(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      check("and", result, 32'hF000_F000);
      issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      check("or", result, 32'hFFF0_FFF0);
      issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
      check("xor", result, 32'h0FF0_0FF0);

      // Compares, zero shift, reserved op
      issue(4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("slt", result, 32'd1);
      check("slt_zf", {31'b0, zero_flag}, 32'd0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("sltu", result, 32'd0);
      issue(4'd7, 32'h0000_1234, 32'd0, 1'b0);
      check("sll0_valid", {31'b0, out_valid}, 32'd1);
      check("sll0", result, 32'h0000_1234);
      issue(4'd7, 32'hABCD_0001, 32'd32, 1'b0);
      check("sll32_valid", {31'b0, out_valid}, 32'd1);
      check("sll32", result, 32'hABCD_0001);
      issue(4'd12, 32'd7, 32'd9, 1'b0);
      check("rsvd", result, 32'd0);
      check("rsvd_zf", {31'b0, zero_flag}, 32'd1);

      // Long arithmetic shift
      tick();
      issue(4'd9, 32'h8000_0000, 32'd31, 1'b0);
      wait_valid(cycles, busy_cnt);
      check("sra_latency", cycles, 32'd32);
      check("sra_busy", busy_cnt, 32'd31);
      check("sra", result, 32'hFFFF_FFFF);
      check("sra_zf", {31'b0, zero_flag}, 32'd0);

      // Upper op_b bits ignored; zero_inv sampled at accept only
      tick();
      issue(4'd8, 32'h0000_00F0, 32'hFFFF_FF04, 1'b0);
      wait_valid(cycles, busy_cnt);
      check("srl_latency", cycles, 32'd5);
      check("srl", result, 32'h0000_000F);
      tick();
      drive(4'd7, 32'd1, 32'd3, 1'b1);
      tick();
      in_valid = 1'b0; zero_inv = 1'b0; op_a = 32'hDEAD_BEEF;
      wait_valid(cycles, busy_cnt);
      check("sll_latency", cycles, 32'd4);
      check("sll", result, 32'd8);
      check("sll_zf", {31'b0, zero_flag}, 32'd1);

      // Back-pressure in HOLD, then back-to-back accept
      tick();
      out_ready = 1'b0;
      issue(4'd0, 32'd10, 32'd20, 1'b0);
      drive(4'd1, 32'd1, 32'd1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         check("hold_result", result, 32'd30);
         check("hold_ready", {31'b0, in_ready}, 32'd0);
         tick();
      end
      check("hold_valid", {31'b0, out_valid}, 32'd1);
      out_ready = 1'b1;
      drive(4'd0, 32'd7, 32'd8, 1'b0);
      #1;
      check("b2b_ready", {31'b0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_result", result, 32'd15);
      tick();
      check("drain_valid", {31'b0, out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
